// File: rtl/cache_addr_sequencer_if.sv
// Request/beat handshake bundle for the cache address sequencer.
// slave: the sequencer side; master: the request source and beat consumer.
interface cache_addr_sequencer_if #(
  parameter int ADDR_W   = 32,
  parameter int SET_W    = 2,
  parameter int OFFSET_W = 2
);
  localparam int TAG_W = ADDR_W - SET_W - OFFSET_W;

  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_addr;
  logic                in_burst;
  logic                out_valid;
  logic                out_ready;
  logic [TAG_W-1:0]    out_tag;
  logic [SET_W-1:0]    out_set;
  logic [OFFSET_W-1:0] out_offset;
  logic                out_first;
  logic                out_last;
  logic                busy;

  modport slave (
    input  in_valid,
    input  in_addr,
    input  in_burst,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_tag,
    output out_set,
    output out_offset,
    output out_first,
    output out_last,
    output busy
  );

  modport master (
    output in_valid,
    output in_addr,
    output in_burst,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_tag,
    input  out_set,
    input  out_offset,
    input  out_first,
    input  out_last,
    input  busy
  );
endinterface

// File: rtl/cache_addr_sequencer.sv
// Splits request addresses into tag/set/offset beats; bursts expand
// into a critical-word-first line refill with wrapping offsets.
module cache_addr_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int SET_W    = 2,
  parameter int OFFSET_W = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  cache_addr_sequencer_if.slave bus
);
  localparam int TAG_W = ADDR_W - SET_W - OFFSET_W;

  localparam logic [OFFSET_W:0] LINE_BEATS =
    {1'b1, {OFFSET_W{1'b0}}};
  localparam logic [OFFSET_W:0] ONE_BEAT =
    {{OFFSET_W{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic                first_q, first_d;
  logic [OFFSET_W:0]   rem_q, rem_d;

  logic emit;
  logic last;
  logic ready;
  logic accept;
  logic advance;

  // rem_q counts beats still owed, including the one on the bus
  assign emit    = (state_q == EMIT);
  assign last    = emit && (rem_q == ONE_BEAT);
  assign ready   = !emit || (bus.out_ready && last);
  assign accept  = bus.in_valid && ready;
  assign advance = emit && bus.out_ready;

  assign bus.in_ready   = ready;
  assign bus.out_valid  = emit;
  assign bus.out_tag    = tag_q;
  assign bus.out_set    = set_q;
  assign bus.out_offset = off_q;
  assign bus.out_first  = emit && first_q;
  assign bus.out_last   = last;
  assign bus.busy       = emit && !last;

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    set_d   = set_q;
    off_d   = off_q;
    first_d = first_q;
    rem_d   = rem_q;
    unique case (1'b1)
      accept: begin
        state_d = EMIT;
        tag_d   = bus.in_addr[ADDR_W-1 -: TAG_W];
        set_d   = bus.in_addr[OFFSET_W +: SET_W];
        off_d   = bus.in_addr[OFFSET_W-1:0];
        first_d = 1'b1;
        rem_d   = bus.in_burst ? LINE_BEATS
                               : ONE_BEAT;
      end
      (advance && last && !bus.in_valid): begin
        state_d = IDLE;
      end
      (advance && !last): begin
        off_d   = off_q + 1'b1;
        first_d = 1'b0;
        rem_d   = rem_q - ONE_BEAT;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
      set_q   <= '0;
      off_q   <= '0;
      first_q <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      set_q   <= set_d;
      off_q   <= off_d;
      first_q <= first_d;
      rem_q   <= rem_d;
    end
  end
endmodule
